// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D cache memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        COOL  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_I    = 2'd1,
        GRANT_D    = 2'd2
    } grant_t;

    // Requester served most recently; round-robin favours the other one.
    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } side_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way picker between I and D requests: round-robin on `last`, or D-first when fixed.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic       i_last,
    input  logic       i_fixed,
    output logic [1:0] o_pick
);

    always_comb begin
        o_pick = GRANT_NONE;
        if (i_req_i && i_req_d) begin
            o_pick = (i_fixed || (i_last == LAST_I)) ? GRANT_D : GRANT_I;
        end else if (i_req_d) begin
            o_pick = GRANT_D;
        end else if (i_req_i) begin
            o_pick = GRANT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between I- and D-cache; one grant at a time,
// followed by a single cool-down cycle that hides the finished cache's lingering request.
//
// state | meaning
// IDLE  | no grant; pick a requester
// GNT_I | I-cache owns the memory port until mem_ready
// GNT_D | D-cache owns the memory port until mem_ready
// COOL  | one cycle after mem_ready; outputs quiet, no new grant
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    arb_state_t r_state, w_next_state;
    grant_t     r_grant, w_next_grant;
    side_t      r_last,  w_next_last;
    logic [1:0] w_pick_raw;
    grant_t     w_pick;
    logic       w_gnt_i, w_gnt_d;

    arb_rr2 u_rr2 (
        .i_req_i (i_mem_read),
        .i_req_d (d_mem_read | d_mem_write),
        .i_last  (r_last),
        .i_fixed (FIXED_PRIO != 0),
        .o_pick  (w_pick_raw)
    );

    assign w_pick = grant_t'(w_pick_raw);

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state <= IDLE;
            r_grant <= GRANT_NONE;
            r_last  <= LAST_I;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_last  <= w_next_last;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_last  = r_last;
        case (r_state)
            IDLE: begin
                if (w_pick == GRANT_I) begin
                    w_next_state = GNT_I;
                    w_next_grant = GRANT_I;
                end else if (w_pick == GRANT_D) begin
                    w_next_state = GNT_D;
                    w_next_grant = GRANT_D;
                end
            end
            // The grant is held until mem_ready even if the requester drops early.
            GNT_I: begin
                if (mem_ready) begin
                    w_next_state = COOL;
                    w_next_grant = GRANT_NONE;
                    w_next_last  = LAST_I;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    w_next_state = COOL;
                    w_next_grant = GRANT_NONE;
                    w_next_last  = LAST_D;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_grant = GRANT_NONE;
            end
        endcase
    end

    assign w_gnt_i = (r_grant == GRANT_I);
    assign w_gnt_d = (r_grant == GRANT_D);

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        if (w_gnt_i) begin
            mem_read    = i_mem_read;
            mem_addr    = i_mem_addr;
            i_mem_ready = mem_ready;
        end else if (w_gnt_d) begin
            mem_read    = d_mem_read;
            mem_write   = d_mem_write;
            mem_addr    = d_mem_addr;
            mem_wdata   = d_mem_wdata;
            d_mem_ready = mem_ready;
        end
    end

    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign busy        = (r_state == GNT_I) || (r_state == GNT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: round-robin instance u0 and fixed-priority instance u1.
module tb_mem_arbiter;

    localparam int AW  = 28;
    localparam int DW  = 128;
    localparam int LAT = 5;

    typedef struct packed {
        logic          is_d;
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          i_rd, i_rdy, d_rd, d_wr, d_rdy, m_rd, m_wr, m_rdy, busy;
    logic          m_rdy_model, m_spur;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
    assign m_rdy = m_rdy_model | m_spur;

    logic          i_rd1, i_rdy1, d_rd1, d_wr1, d_rdy1, m_rd1, m_wr1, m_rdy1, busy1;
    logic [AW-1:0] i_addr1, d_addr1, m_addr1;
    logic [DW-1:0] i_rdata1, d_rdata1, d_wdata1, m_wdata1, m_rdata1;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u0 (
        .clk(clk), .proc_reset_n(rst_n),
        .i_mem_read(i_rd), .i_mem_addr(i_addr), .i_mem_rdata(i_rdata), .i_mem_ready(i_rdy),
        .d_mem_read(d_rd), .d_mem_write(d_wr), .d_mem_addr(d_addr), .d_mem_wdata(d_wdata),
        .d_mem_rdata(d_rdata), .d_mem_ready(d_rdy),
        .mem_read(m_rd), .mem_write(m_wr), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata), .mem_ready(m_rdy), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u1 (
        .clk(clk), .proc_reset_n(rst_n),
        .i_mem_read(i_rd1), .i_mem_addr(i_addr1), .i_mem_rdata(i_rdata1), .i_mem_ready(i_rdy1),
        .d_mem_read(d_rd1), .d_mem_write(d_wr1), .d_mem_addr(d_addr1), .d_mem_wdata(d_wdata1),
        .d_mem_rdata(d_rdata1), .d_mem_ready(d_rdy1),
        .mem_read(m_rd1), .mem_write(m_wr1), .mem_addr(m_addr1), .mem_wdata(m_wdata1),
        .mem_rdata(m_rdata1), .mem_ready(m_rdy1), .busy(busy1)
    );

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_served = 0;
    txn_t exp_q[$];
    logic exp1_q[$];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {4{32'hDEADBEEF}} ^ DW'(a);
    endfunction

    function automatic txn_t mk(input logic is_d, input logic is_wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd);
        txn_t t;
        t.is_d = is_d; t.is_wr = is_wr; t.addr = a; t.wdata = wd;
        return t;
    endfunction

    // Memory model for u0: accepts each new transaction against the scoreboard, answers after LAT cycles.
    int   m_cnt     = 0;
    logic m_echo    = 1'b0;
    logic m_echo_en = 1'b0;
    txn_t m_cur;
    initial begin
        m_rdy_model = 1'b0;
        m_rdata     = '0;
        m_cur       = '0;
        forever begin
            @(posedge clk); #2;
            m_rdy_model = 1'b0;
            if (!rst_n) begin
                m_cnt  = 0;
                m_echo = 1'b0;
            end else if (m_echo) begin
                m_echo = 1'b0;
                m_rdy_model = 1'b1;
                #1;
                check_val("cool_spur_i_ready", 128'(i_rdy), 128'(0));
                check_val("cool_spur_d_ready", 128'(d_rdy), 128'(0));
                check_val("cool_busy", 128'(busy), 128'(0));
            end else if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_rdy_model = 1'b1;
                    m_rdata = line_of(m_cur.addr);
                    #1;
                    check_val("i_ready_routing", 128'(i_rdy), 128'(!m_cur.is_d));
                    check_val("d_ready_routing", 128'(d_rdy), 128'(m_cur.is_d));
                    check_val("i_rdata_bcast", i_rdata, line_of(m_cur.addr));
                    check_val("d_rdata_bcast", d_rdata, line_of(m_cur.addr));
                    n_served++;
                    m_echo = m_echo_en;
                end
            end else if (m_rd || m_wr) begin
                check_val("txn_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    m_cur = exp_q.pop_front();
                    check_val("mem_addr", 128'(m_addr), 128'(m_cur.addr));
                    check_val("mem_write", 128'(m_wr), 128'(m_cur.is_wr));
                    check_val("mem_read", 128'(m_rd), 128'(!m_cur.is_wr));
                    if (m_cur.is_wr) check_val("mem_wdata", m_wdata, m_cur.wdata);
                    m_cnt = LAT;
                end
            end
        end
    end

    // Memory model for u1: two-cycle answer; the scoreboard holds the expected winner (1 = D).
    int   m_cnt1 = 0;
    logic e1;
    initial begin
        m_rdy1   = 1'b0;
        m_rdata1 = '0;
        forever begin
            @(posedge clk); #2;
            m_rdy1 = 1'b0;
            if (!rst_n) begin
                m_cnt1 = 0;
            end else if (m_cnt1 != 0) begin
                m_cnt1--;
                if (m_cnt1 == 0) begin
                    m_rdy1 = 1'b1;
                    #1;
                    check_val("fix_txn_expected", 128'(exp1_q.size() != 0), 128'(1));
                    if (exp1_q.size() != 0) begin
                        e1 = exp1_q.pop_front();
                        check_val("fix_d_granted", 128'(d_rdy1), 128'(e1));
                        check_val("fix_i_granted", 128'(i_rdy1), 128'(!e1));
                    end
                end
            end else if (m_rd1 || m_wr1) begin
                m_cnt1 = 2;
            end
        end
    end

    // Cache behaviour: hold the request until ready, keep it for one more cycle, then drop.
    task automatic i_txn(input logic [AW-1:0] a);
        int k = 0;
        i_addr = a;
        i_rd   = 1'b1;
        do begin @(negedge clk); k++; end while (!i_rdy && k < 200);
        check_val("i_ready_seen", 128'(i_rdy), 128'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rd = 1'b0;
    endtask

    task automatic d_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int k = 0;
        d_addr  = a;
        d_wdata = wd;
        d_rd    = !wr;
        d_wr    = wr;
        do begin @(negedge clk); k++; end while (!d_rdy && k < 200);
        check_val("d_ready_seen", 128'(d_rdy), 128'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_rd = 1'b0;
        d_wr = 1'b0;
    endtask

    task automatic i1_txn(input logic [AW-1:0] a);
        int k = 0;
        i_addr1 = a;
        i_rd1   = 1'b1;
        do begin @(negedge clk); k++; end while (!i_rdy1 && k < 200);
        check_val("fix_i_ready_seen", 128'(i_rdy1), 128'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rd1 = 1'b0;
    endtask

    task automatic d1_txn(input logic [AW-1:0] a);
        int k = 0;
        d_addr1 = a;
        d_rd1   = 1'b1;
        do begin @(negedge clk); k++; end while (!d_rdy1 && k < 200);
        check_val("fix_d_ready_seen", 128'(d_rdy1), 128'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_rd1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        i_rd = 0; i_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0; m_spur = 0;
        i_rd1 = 0; i_addr1 = '0; d_rd1 = 0; d_wr1 = 0; d_addr1 = '0; d_wdata1 = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_mem_read", 128'(m_rd), 128'(0));
        check_val("rst_mem_write", 128'(m_wr), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_mem_addr", 128'(m_addr), 128'(0));
        check_val("rst_busy_fix", 128'(busy1), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single I read with latency check.
        exp_q.push_back(mk(1'b0, 1'b0, 28'h0000010, '0));
        fork
            i_txn(28'h0000010);
            begin
                @(negedge clk);
                check_val("lat_idle_read", 128'(m_rd), 128'(0));
                @(negedge clk);
                check_val("lat_gnt_read", 128'(m_rd), 128'(1));
                check_val("lat_gnt_addr", 128'(m_addr), 128'(28'h0000010));
                check_val("lat_gnt_busy", 128'(busy), 128'(1));
            end
        join
        @(negedge clk);
        check_val("idle_after_i", 128'(busy), 128'(0));

        // Spurious ready in IDLE.
        @(posedge clk); #1 m_spur = 1'b1;
        #1;
        check_val("idle_spur_i_ready", 128'(i_rdy), 128'(0));
        check_val("idle_spur_d_ready", 128'(d_rdy), 128'(0));
        @(negedge clk);
        check_val("idle_spur_busy", 128'(busy), 128'(0));
        @(posedge clk); #1 m_spur = 1'b0;
        @(negedge clk);
        check_val("idle_spur_state", 128'(busy), 128'(0));
        @(posedge clk); #1;

        // D write-back then immediate refill, spurious ready in each COOL.
        m_echo_en = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 28'h0000A07, {16{8'h11}}));
        exp_q.push_back(mk(1'b1, 1'b0, 28'h0000127, '0));
        d_txn(1'b1, 28'h0000A07, {16{8'h11}});
        d_txn(1'b0, 28'h0000127, '0);
        m_echo_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a D write grant.
        exp_q.push_back(mk(1'b1, 1'b1, 28'h0000A55, {16{8'h5A}}));
        d_addr = 28'h0000A55; d_wdata = {16{8'h5A}}; d_wr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("pre_rst_busy", 128'(busy), 128'(1));
        check_val("pre_rst_write", 128'(m_wr), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_async_write", 128'(m_wr), 128'(0));
        check_val("rst_async_busy", 128'(busy), 128'(0));
        d_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (i_rdy || d_rdy || busy || m_rd || m_wr) rdy_seen++;
        end
        check_val("post_rst_quiet", 128'(rdy_seen), 128'(0));
        @(posedge clk); #1;

        // Continuous contention after reset: D first, then strict alternation.
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(1'b1, 1'b0, AW'(28'h200 + k), '0));
            exp_q.push_back(mk(1'b0, 1'b0, AW'(28'h100 + k), '0));
        end
        fork
            for (int k = 0; k < 8; k++) i_txn(AW'(28'h100 + k));
            for (int k = 0; k < 8; k++) d_txn(1'b0, AW'(28'h200 + k), '0);
        join
        repeat (4) @(posedge clk);
        #1;
        check_val("sb_empty", 128'(exp_q.size()), 128'(0));
        check_val("served_count", 128'(n_served), 128'(19));

        // Fixed priority: I waits for the D stream to stop.
        for (int k = 0; k < 4; k++) exp1_q.push_back(1'b1);
        exp1_q.push_back(1'b0);
        fork
            i1_txn(28'h0000333);
            for (int k = 0; k < 4; k++) d1_txn(AW'(28'h400 + k));
        join
        repeat (4) @(posedge clk);
        #1;
        check_val("fix_sb_empty", 128'(exp1_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
